// File: rtl/als_err_acc.sv
// Error-statistics accumulator for characterising an approximate adder against an
// exact reference: counts mismatches, tracks the worst and the total error distance.
module als_err_acc #(
    parameter int WIDTH = 33,
    parameter int CNT_W = 20,
    parameter int ACC_W = 56
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] n_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] approx_in,
    input  logic [WIDTH-1:0] exact_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_cnt,
    output logic [WIDTH-1:0] max_ed,
    output logic [ACC_W-1:0] sum_ed
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_n;
    logic [CNT_W-1:0] r_cnt;
    logic             r_flush;
    logic             r_s1_vld;
    logic [WIDTH-1:0] r_s1_diff;
    logic             r_s1_mis;
    logic [CNT_W-1:0] r_err;
    logic [WIDTH-1:0] r_max;
    logic [ACC_W-1:0] r_sum;
    logic             r_in_ready;
    logic             r_busy;
    logic             r_done;
    logic             w_accept;
    logic             w_start_ok;
    logic             w_last;

    function automatic logic [WIDTH-1:0] abs_diff(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        abs_diff = (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                 input logic [WIDTH-1:0] d);
        logic [ACC_W:0] w_sum;
        w_sum = {1'b0, acc} + (ACC_W+1)'(d);
        sat_add = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
    endfunction

    assign w_accept   = in_valid && r_in_ready;
    assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last     = w_accept && ((r_cnt + CNT_W'(1)) == r_n);

    // Next-state decode; start is only honoured between runs
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_start_ok) begin
                    w_next = (n_samples == {CNT_W{1'b0}}) ? FLUSH : RUN;
                end else begin
                    w_next = r_state;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next = FLUSH;
                end else begin
                    w_next = RUN;
                end
            end
            FLUSH: begin
                if (r_flush) begin
                    w_next = DONE;
                end else begin
                    w_next = FLUSH;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State register, run bookkeeping and status flags registered from next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_n        <= {CNT_W{1'b0}};
            r_cnt      <= {CNT_W{1'b0}};
            r_flush    <= 1'b0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_flush    <= (r_state == FLUSH) && !r_flush;
            r_in_ready <= (w_next == RUN);
            r_busy     <= (w_next == RUN) || (w_next == FLUSH);
            r_done     <= (w_next == DONE);
            if (w_start_ok) begin
                r_n   <= n_samples;
                r_cnt <= {CNT_W{1'b0}};
            end else if (w_accept) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    // Stage 1: absolute difference and mismatch flag of the accepted pair
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_diff <= {WIDTH{1'b0}};
            r_s1_mis  <= 1'b0;
        end else begin
            r_s1_vld  <= w_accept && !w_start_ok;
            r_s1_diff <= abs_diff(approx_in, exact_in);
            r_s1_mis  <= (approx_in != exact_in);
        end
    end

    // Stage 2: fold the difference into the run statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= {CNT_W{1'b0}};
            r_max <= {WIDTH{1'b0}};
            r_sum <= {ACC_W{1'b0}};
        end else if (w_start_ok) begin
            r_err <= {CNT_W{1'b0}};
            r_max <= {WIDTH{1'b0}};
            r_sum <= {ACC_W{1'b0}};
        end else if (r_s1_vld) begin
            r_err <= r_s1_mis ? (r_err + CNT_W'(1)) : r_err;
            r_max <= (r_s1_diff > r_max) ? r_s1_diff : r_max;
            r_sum <= sat_add(r_sum, r_s1_diff);
        end else begin
            r_err <= r_err;
            r_max <= r_max;
            r_sum <= r_sum;
        end
    end

    assign in_ready = r_in_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err_cnt  = r_err;
    assign max_ed   = r_max;
    assign sum_ed   = r_sum;

endmodule

// File: tb/tb_als_err_acc.sv
// Directed bench for als_err_acc: stimulus pushes expected run results, a monitor
// pops and compares them (including done timing) whenever done rises.
module tb_als_err_acc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [19:0] n_samples = 20'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [32:0] approx_in = 33'd0;
    logic [32:0] exact_in = 33'd0;
    logic        busy;
    logic        done;
    logic [19:0] err_cnt;
    logic [32:0] max_ed;
    logic [55:0] sum_ed;

    typedef struct {
        logic [19:0] err;
        logic [32:0] max;
        logic [55:0] sum;
        int          dcyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_acc = 0;
    int   st_cyc = 0;
    logic done_q = 1'b0;

    als_err_acc dut (
        .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
        .in_valid(in_valid), .in_ready(in_ready),
        .approx_in(approx_in), .exact_in(exact_in),
        .busy(busy), .done(done), .err_cnt(err_cnt), .max_ed(max_ed), .sum_ed(sum_ed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: on each rising edge of done compare against the oldest expectation
    always @(negedge clk) begin
        if (done && !done_q) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("err_cnt", 64'(err_cnt), 64'(e.err));
                chk("max_ed", 64'(max_ed), 64'(e.max));
                chk("sum_ed", 64'(sum_ed), 64'(e.sum));
                chk("done_cycle", 64'(cyc), 64'(e.dcyc));
            end
        end
        done_q = done;
    end

    task automatic start_run(input logic [19:0] n);
        start = 1'b1;
        n_samples = n;
        st_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [32:0] a, input logic [32:0] b);
        logic got;
        got = 1'b0;
        in_valid = 1'b1;
        approx_in = a;
        exact_in = b;
        for (int k = 0; k < 50; k++) begin
            if (in_ready) begin
                got = 1'b1;
                last_acc = cyc;
            end
            @(negedge clk);
            if (got) break;
        end
        in_valid = 1'b0;
        if (!got) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic finish_run(input logic [19:0] e_err, input logic [32:0] e_max,
                              input logic [55:0] e_sum, input int base);
        exp_t e;
        logic seen;
        e.err = e_err;
        e.max = e_max;
        e.sum = e_sum;
        e.dcyc = base + 3;
        exp_q.push_back(e);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) chk("done_timeout", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    initial begin
        logic rdy_seen;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_sum", 64'(sum_ed), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back run
        start_run(20'd4);
        chk("run_busy", 64'(busy), 64'd1);
        send(33'd10, 33'd10);
        send(33'd10, 33'd13);
        send(33'd7, 33'd2);
        send(33'd0, 33'd0);
        finish_run(20'd2, 33'd5, 56'd8, last_acc);

        // Empty run: straight to FLUSH, never ready
        start_run(20'd0);
        rdy_seen = in_ready;
        @(negedge clk);
        rdy_seen = rdy_seen | in_ready;
        chk("n0_ready", 64'(rdy_seen), 64'd0);
        finish_run(20'd0, 33'd0, 56'd0, st_cyc);

        // Gapped run with extreme operands
        start_run(20'd3);
        send(33'd0, 33'h1FFFFFFFF);
        @(negedge clk);
        send(33'd5, 33'd5);
        @(negedge clk);
        send(33'h1FFFFFFFF, 33'd0);
        finish_run(20'd2, 33'h1FFFFFFFF, 56'h3FFFFFFFE, last_acc);

        // Asynchronous reset mid-run
        start_run(20'd5);
        send(33'd1, 33'd9);
        send(33'd2, 33'd2);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_ready", 64'(in_ready), 64'd0);
        chk("arst_err", 64'(err_cnt), 64'd0);
        chk("arst_max", 64'(max_ed), 64'd0);
        chk("arst_sum", 64'(sum_ed), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_ready", 64'(in_ready), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);
        in_valid = 1'b0;
        start_run(20'd1);
        send(33'd1, 33'd2);
        finish_run(20'd1, 33'd1, 56'd1, last_acc);

        // Start pulsed during RUN is ignored
        start_run(20'd3);
        send(33'd4, 33'd1);
        start = 1'b1;
        n_samples = 20'd1;
        send(33'd2, 33'd9);
        start = 1'b0;
        chk("mid_start_busy", 64'(busy), 64'd1);
        send(33'd6, 33'd6);
        finish_run(20'd2, 33'd7, 56'd10, last_acc);

        // Restart from DONE clears statistics on the next cycle
        start_run(20'd2);
        chk("restart_done", 64'(done), 64'd0);
        chk("restart_busy", 64'(busy), 64'd1);
        chk("restart_err", 64'(err_cnt), 64'd0);
        chk("restart_max", 64'(max_ed), 64'd0);
        chk("restart_sum", 64'(sum_ed), 64'd0);
        send(33'd100, 33'd50);
        send(33'd50, 33'd100);
        finish_run(20'd2, 33'd50, 56'd100, last_acc);

        repeat (3) @(negedge clk);
        chk("done_hold", 64'(done), 64'd1);
        chk("stats_hold", 64'(sum_ed), 64'd100);
        chk("pending_expectations", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
